// File: rtl/periph_timer_bank_pkg.sv
// Shared definitions for the peripheral timer bank: register offsets,
// TCON bit positions and the per-channel register selector.
package periph_timer_bank_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    // Byte distance between consecutive channel register blocks
    localparam logic [31:0] CH_STRIDE = 32'h0000_0010;

    // Offsets inside a channel block
    localparam logic [3:0] OFF_TH    = 4'h0;
    localparam logic [3:0] OFF_TL    = 4'h4;
    localparam logic [3:0] OFF_TCON  = 4'h8;
    localparam logic [3:0] OFF_PRESC = 4'hC;

    // Offset of the status register inside the global block
    localparam logic [31:0] OFF_IRQ_STAT = 32'h0000_0000;

    // TCON layout
    localparam int TCON_W       = 3;
    localparam int TCON_EN      = 0;
    localparam int TCON_IRQ_EN  = 1;
    localparam int TCON_ONESHOT = 2;

    typedef enum logic [1:0] {
        REG_TH    = 2'd0,
        REG_TL    = 2'd1,
        REG_TCON  = 2'd2,
        REG_PRESC = 2'd3
    } reg_sel_e;

    // Map a word-aligned in-block offset onto the channel register it selects
    function automatic reg_sel_e reg_sel(input logic [3:0] off);
        reg_sel_e sel;
        case (off)
            OFF_TL:    sel = REG_TL;
            OFF_TCON:  sel = REG_TCON;
            OFF_PRESC: sel = REG_PRESC;
            default:   sel = REG_TH;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/periph_timer_bank_timer_channel.sv
// One timer channel: reload (TH), count (TL), control (TCON), prescaler
// (PRESC) and the hidden prescale counter. Emits a one-cycle wrap_irq pulse
// when the count wraps with interrupts enabled.
module periph_timer_bank_timer_channel
    import periph_timer_bank_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_we_th,
    input  logic               i_we_tl,
    input  logic               i_we_tcon,
    input  logic               i_we_presc,
    input  logic [31:0]        i_wdata,
    output logic [CNT_W-1:0]   o_th,
    output logic [CNT_W-1:0]   o_tl,
    output logic [TCON_W-1:0]  o_tcon,
    output logic [PRESC_W-1:0] o_presc,
    output logic               o_wrap_irq
);

    logic [CNT_W-1:0]   r_th;
    logic [CNT_W-1:0]   r_tl;
    logic [TCON_W-1:0]  r_tcon;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pc;

    logic w_tick;
    logic w_at_max;
    logic w_wrap;

    assign w_tick   = r_tcon[TCON_EN] && (r_pc == r_presc);
    assign w_at_max = (r_tl == {CNT_W{1'b1}});
    // The wrap event stands even if software overwrites TL on the same edge
    assign w_wrap   = w_tick && w_at_max;

    assign o_wrap_irq = w_wrap && r_tcon[TCON_IRQ_EN];
    assign o_th       = r_th;
    assign o_tl       = r_tl;
    assign o_tcon     = r_tcon;
    assign o_presc    = r_presc;

    // Reload and prescale registers: written only by the bus
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_th    <= '0;
            r_presc <= '0;
        end else begin
            if (i_we_th) begin
                r_th <= i_wdata[CNT_W-1:0];
            end
            if (i_we_presc) begin
                r_presc <= i_wdata[PRESC_W-1:0];
            end
        end
    end

    // Count register: bus write beats the tick, wrap reloads from TH
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tl <= '0;
        end else if (i_we_tl) begin
            r_tl <= i_wdata[CNT_W-1:0];
        end else if (w_wrap) begin
            r_tl <= r_th;
        end else if (w_tick) begin
            r_tl <= r_tl + CNT_W'(1);
        end
    end

    // Control register: bus write beats the one-shot self-disable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcon <= '0;
        end else if (i_we_tcon) begin
            r_tcon <= i_wdata[TCON_W-1:0];
        end else if (w_wrap && r_tcon[TCON_ONESHOT]) begin
            r_tcon[TCON_EN] <= 1'b0;
        end
    end

    // Prescale counter: restarts on TCON writes, while disabled and on each tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= '0;
        end else if (i_we_tcon || !r_tcon[TCON_EN] || w_tick) begin
            r_pc <= '0;
        end else begin
            r_pc <= r_pc + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/periph_timer_bank.sv
// Memory-mapped bank of N_CH up-counting timers. Decodes the bus, muxes
// combinational reads, keeps the write-1-to-clear interrupt status and
// drives the single interrupt line.
module periph_timer_bank
    import periph_timer_bank_pkg::*;
#(
    parameter int          N_CH      = 4,
    parameter int          CNT_W     = 32,
    parameter int          PRESC_W   = 8,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd,
    input  logic            wr,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irqout,
    output logic [N_CH-1:0] ch_irq
);

    // Offset of the global block from BASE_ADDR
    localparam logic [31:0] GOFF = CH_STRIDE * 32'(N_CH);

    logic [31:0]  w_off;
    logic         w_aligned;
    logic         w_in_ch;
    logic         w_is_stat;
    logic [2:0]   w_ch_sel;
    reg_sel_e     w_reg;

    logic [CNT_W-1:0]   w_th    [N_CH];
    logic [CNT_W-1:0]   w_tl    [N_CH];
    logic [TCON_W-1:0]  w_tcon  [N_CH];
    logic [PRESC_W-1:0] w_presc [N_CH];
    logic [N_CH-1:0]    w_wrap;

    logic [N_CH-1:0] w_clr;
    logic [N_CH-1:0] w_irq_stat_nxt;
    logic [N_CH-1:0] r_irq_stat;

    // Addresses below BASE_ADDR wrap to huge offsets and fall outside both ranges
    assign w_off     = addr - BASE_ADDR;
    assign w_aligned = (addr[1:0] == 2'b00);
    assign w_in_ch   = w_aligned && (w_off < GOFF);
    assign w_is_stat = w_aligned && (w_off == GOFF + OFF_IRQ_STAT);
    assign w_ch_sel  = w_off[6:4];
    assign w_reg     = reg_sel(w_off[3:0]);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic w_hit;
        assign w_hit = wr && w_in_ch && (w_ch_sel == 3'(c));

        periph_timer_bank_timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .i_clk      (clk),
            .i_rst_n    (reset),
            .i_we_th    (w_hit && (w_reg == REG_TH)),
            .i_we_tl    (w_hit && (w_reg == REG_TL)),
            .i_we_tcon  (w_hit && (w_reg == REG_TCON)),
            .i_we_presc (w_hit && (w_reg == REG_PRESC)),
            .i_wdata    (wdata),
            .o_th       (w_th[c]),
            .o_tl       (w_tl[c]),
            .o_tcon     (w_tcon[c]),
            .o_presc    (w_presc[c]),
            .o_wrap_irq (w_wrap[c])
        );
    end

    // Combinational read mux, zero unless a mapped register is being read
    always_comb begin
        rdata = '0;
        if (rd && w_is_stat) begin
            rdata[N_CH-1:0] = r_irq_stat;
        end else if (rd && w_in_ch) begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_ch_sel == 3'(c)) begin
                    case (w_reg)
                        REG_TH:    rdata[CNT_W-1:0]   = w_th[c];
                        REG_TL:    rdata[CNT_W-1:0]   = w_tl[c];
                        REG_TCON:  rdata[TCON_W-1:0]  = w_tcon[c];
                        REG_PRESC: rdata[PRESC_W-1:0] = w_presc[c];
                        default:   rdata              = '0;
                    endcase
                end
            end
        end
    end

    // A new wrap in the same cycle as a clear keeps the bit set
    assign w_clr          = (wr && w_is_stat) ? wdata[N_CH-1:0] : '0;
    assign w_irq_stat_nxt = (r_irq_stat & ~w_clr) | w_wrap;

    // Pending interrupt status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_stat <= '0;
        end else begin
            r_irq_stat <= w_irq_stat_nxt;
        end
    end

    assign ch_irq = r_irq_stat;
    assign irqout = |r_irq_stat;

endmodule

// File: tb/tb_periph_timer_bank.sv
// Self-checking bench for periph_timer_bank: a register read/write vector
// table followed by hand-written multi-cycle timer sequences.
module tb_periph_timer_bank;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam logic [31:0] GBASE = 32'h4000_0040;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irqout;
    logic [3:0]  ch_irq;

    periph_timer_bank #(
        .N_CH      (4),
        .CNT_W     (32),
        .PRESC_W   (8),
        .BASE_ADDR (BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irqout (irqout),
        .ch_irq (ch_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          wen;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] ra(input int ch, input int off);
        return BASE + 32'(16 * ch + off);
    endfunction

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr    = 1'b0;
        wdata = '0;
    endtask

    task automatic chk_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
        rd   = 1'b1;
        addr = a;
        #1;
        e = exp_q.pop_front();
        chk_val(e.name, rdata, e.exp);
        rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{ra(3, 'h0), 32'hA5A5_0001, 1'b1, 32'hA5A5_0001};
        vecs[1]  = '{ra(3, 'hC), 32'h0000_1234, 1'b1, 32'h0000_0034};
        vecs[2]  = '{ra(3, 'h8), 32'hFFFF_FFF8, 1'b1, 32'h0000_0000};
        vecs[3]  = '{ra(2, 'h4), 32'h1234_5678, 1'b1, 32'h1234_5678};
        vecs[4]  = '{ra(1, 'hC), 32'h0000_00FF, 1'b1, 32'h0000_00FF};
        vecs[5]  = '{GBASE + 32'h4, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
        vecs[6]  = '{32'h4000_0002, 32'h0, 1'b0, 32'h0000_0000};
        vecs[7]  = '{32'h3FFF_FFF0, 32'h0, 1'b0, 32'h0000_0000};
        vecs[8]  = '{GBASE, 32'h0000_000F, 1'b1, 32'h0000_0000};
        vecs[9]  = '{ra(3, 'h0), 32'h0, 1'b0, 32'hA5A5_0001};
        vecs[10] = '{32'h4000_0050, 32'h0, 1'b0, 32'h0000_0000};

        step(2);
        reset = 1'b1;
        step(1);

        // Register table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wen) begin
                wr_reg(vecs[i].addr, vecs[i].wdata);
            end
            chk_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // rd low gives zero even on a mapped address
        rd   = 1'b0;
        addr = ra(3, 'h0);
        #1;
        chk_val("rd_low_zero", rdata, 32'h0);

        // Reset mid-count
        wr_reg(ra(0, 'h4), 32'h0);
        wr_reg(ra(0, 'h8), 32'h1);
        step(5);
        chk_read("run_tl5", ra(0, 'h4), 32'h5);
        reset = 1'b0;
        #1;
        chk_read("rst_ch0_tl", ra(0, 'h4), 32'h0);
        chk_read("rst_ch0_tcon", ra(0, 'h8), 32'h0);
        chk_read("rst_ch3_th", ra(3, 'h0), 32'h0);
        chk_read("rst_ch3_presc", ra(3, 'hC), 32'h0);
        chk_val("rst_irqout", {31'b0, irqout}, 32'h0);
        chk_val("rst_ch_irq", {28'b0, ch_irq}, 32'h0);
        step(2);
        reset = 1'b1;
        step(3);
        chk_read("post_rst_tl", ra(0, 'h4), 32'h0);
        chk_read("post_rst_tcon", ra(0, 'h8), 32'h0);

        // Periodic ch0
        wr_reg(ra(0, 'h0), 32'hFFFF_FFFC);
        wr_reg(ra(0, 'h4), 32'hFFFF_FFFC);
        wr_reg(ra(0, 'hC), 32'h0);
        wr_reg(ra(0, 'h8), 32'h3);
        step(1);
        chk_read("per_tl1", ra(0, 'h4), 32'hFFFF_FFFD);
        step(1);
        chk_read("per_tl2", ra(0, 'h4), 32'hFFFF_FFFE);
        step(1);
        chk_read("per_tl3", ra(0, 'h4), 32'hFFFF_FFFF);
        chk_read("per_stat3", GBASE, 32'h0);
        chk_val("per_irq3", {31'b0, irqout}, 32'h0);
        step(1);
        chk_read("per_stat4", GBASE, 32'h1);
        chk_val("per_irq4", {31'b0, irqout}, 32'h1);
        chk_val("per_ch_irq4", {28'b0, ch_irq}, 32'h1);
        chk_read("per_reload", ra(0, 'h4), 32'hFFFF_FFFC);
        step(3);
        chk_read("per_tl7", ra(0, 'h4), 32'hFFFF_FFFF);
        step(1);
        chk_read("per_tl8", ra(0, 'h4), 32'hFFFF_FFFC);
        wr_reg(ra(0, 'h8), 32'h0);
        chk_read("pend_held", GBASE, 32'h1);

        // Prescaler + one-shot ch1
        wr_reg(ra(1, 'h0), 32'hFFFF_FFFE);
        wr_reg(ra(1, 'h4), 32'hFFFF_FFFE);
        wr_reg(ra(1, 'hC), 32'h2);
        wr_reg(ra(1, 'h8), 32'h7);
        step(3);
        chk_read("os_tl3", ra(1, 'h4), 32'hFFFF_FFFF);
        step(2);
        chk_val("os_ch_irq5", {28'b0, ch_irq}, 32'h1);
        step(1);
        chk_read("os_stat6", GBASE, 32'h3);
        chk_read("os_tcon6", ra(1, 'h8), 32'h6);
        chk_read("os_tl6", ra(1, 'h4), 32'hFFFF_FFFE);
        step(6);
        chk_read("os_tl_hold", ra(1, 'h4), 32'hFFFF_FFFE);
        chk_read("os_tcon_hold", ra(1, 'h8), 32'h6);

        // W1C and set-wins collision
        wr_reg(GBASE, 32'h1);
        chk_read("w1c_bit0", GBASE, 32'h2);
        chk_val("w1c_irq", {31'b0, irqout}, 32'h1);
        wr_reg(ra(1, 'h8), 32'h7);
        step(5);
        wr_reg(GBASE, 32'h2);
        chk_read("set_wins", GBASE, 32'h2);
        chk_read("os2_tcon", ra(1, 'h8), 32'h6);
        wr_reg(GBASE, 32'h2);
        chk_read("w1c_bit1", GBASE, 32'h0);
        chk_val("w1c_irq_off", {31'b0, irqout}, 32'h0);

        // Bus write to TL on a tick edge, ch3 PRESC=1
        wr_reg(ra(3, 'h0), 32'h0);
        wr_reg(ra(3, 'h4), 32'h0);
        wr_reg(ra(3, 'hC), 32'h1);
        wr_reg(ra(3, 'h8), 32'h1);
        step(1);
        chk_read("bp_tl_pre", ra(3, 'h4), 32'h0);
        wr_reg(ra(3, 'h4), 32'h10);
        chk_read("bp_tl_wr", ra(3, 'h4), 32'h10);
        step(1);
        chk_read("bp_tl_hold", ra(3, 'h4), 32'h10);
        step(1);
        chk_read("bp_tl_inc", ra(3, 'h4), 32'h11);
        wr_reg(ra(3, 'h8), 32'h0);

        // IRQ_EN=0 on ch2: wraps silently
        wr_reg(ra(2, 'h0), 32'hFFFF_FFFF);
        wr_reg(ra(2, 'h4), 32'hFFFF_FFFF);
        wr_reg(ra(2, 'hC), 32'h0);
        wr_reg(ra(2, 'h8), 32'h1);
        step(5);
        chk_read("noirq_tl", ra(2, 'h4), 32'hFFFF_FFFF);
        chk_read("noirq_stat", GBASE, 32'h0);
        chk_val("noirq_irqout", {31'b0, irqout}, 32'h0);
        wr_reg(ra(2, 'h0), 32'h5);
        step(1);
        chk_read("noirq_reload", ra(2, 'h4), 32'h5);
        step(1);
        chk_read("noirq_inc", ra(2, 'h4), 32'h6);
        chk_read("noirq_stat2", GBASE, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
